// File: rtl/coin_payout.sv
// Hopper payout sequencer: emits one coin_out pulse per owed coin, confirms each
// with the drop-sensor ack, and latches a sticky error when the hopper stops acking.
module coin_payout #(
  parameter int unsigned PulseCyc   = 4,
  parameter int unsigned GapCyc     = 8,
  parameter int unsigned AckTimeout = 200,
  parameter int unsigned MaxPayout  = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cur_state_i,
  input  logic       win_valid_i,
  input  logic [3:0] win_amt_i,
  input  logic       hopper_ack_i,
  input  logic       err_clr_i,
  output logic       coin_out_o,
  output logic [3:0] remaining_o,
  output logic       payout_busy_o,
  output logic       payout_done_o,
  output logic       hopper_err_o
);

  localparam logic [3:0] GameScore = 4'd2;
  localparam logic [3:0] GameError = 4'd3;
  localparam logic [7:0] PulseLast = 8'(PulseCyc - 1);
  localparam logic [7:0] GapLast   = 8'(GapCyc - 1);
  localparam logic [7:0] AckLast   = 8'(AckTimeout - 1);
  localparam logic [3:0] MaxAmt    = 4'(MaxPayout);

  typedef enum logic [2:0] {
    StIdle,
    StPulse,
    StWaitAck,
    StGap,
    StDone,
    StFault
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] rem_q, rem_d;
  logic       ack_seen_q, ack_seen_d;
  logic       coin_out_q, busy_q, done_q, err_q;

  logic       abort;
  logic       got_ack;
  logic       last_coin;
  logic [3:0] rem_dec;
  logic [3:0] amt_capped;

  always_comb begin
    abort      = (cur_state_i == GameError) && (state_q != StFault);
    got_ack    = ack_seen_q | hopper_ack_i;
    rem_dec    = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;
    last_coin  = (rem_q <= 4'd1);
    amt_capped = (win_amt_i > MaxAmt) ? MaxAmt : win_amt_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    ack_seen_d = ack_seen_q;

    if (abort) begin
      state_d    = StIdle;
      cnt_d      = 8'd0;
      rem_d      = 4'd0;
      ack_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_valid_i && (cur_state_i == GameScore)) begin
            cnt_d      = 8'd0;
            ack_seen_d = 1'b0;
            rem_d      = amt_capped;
            state_d    = (amt_capped == 4'd0) ? StDone : StPulse;
          end
        end
        StPulse: begin
          if (cnt_q == PulseLast) begin
            cnt_d      = 8'd0;
            ack_seen_d = 1'b0;
            // An ack already seen during the pulse completes the coin right away.
            if (got_ack) begin
              rem_d   = rem_dec;
              state_d = last_coin ? StDone : StGap;
            end else begin
              state_d = StWaitAck;
            end
          end else begin
            cnt_d      = cnt_q + 8'd1;
            ack_seen_d = got_ack;
          end
        end
        StWaitAck: begin
          if (hopper_ack_i) begin
            cnt_d   = 8'd0;
            rem_d   = rem_dec;
            state_d = last_coin ? StDone : StGap;
          end else if (cnt_q == AckLast) begin
            cnt_d   = 8'd0;
            state_d = StFault;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_d      = 8'd0;
            ack_seen_d = 1'b0;
            state_d    = StPulse;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StDone: begin
          rem_d   = 4'd0;
          state_d = StIdle;
        end
        StFault: begin
          // Owed count stays visible until the operator clears the jam.
          if (err_clr_i) begin
            rem_d   = 4'd0;
            state_d = StIdle;
          end
        end
        default: begin
          cnt_d      = 8'd0;
          rem_d      = 4'd0;
          ack_seen_d = 1'b0;
          state_d    = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      rem_q      <= 4'd0;
      ack_seen_q <= 1'b0;
      coin_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      ack_seen_q <= ack_seen_d;
      coin_out_q <= (state_d == StPulse);
      busy_q     <= (state_d == StPulse) || (state_d == StWaitAck) ||
                    (state_d == StGap) || (state_d == StDone);
      done_q     <= (state_d == StDone);
      err_q      <= (state_d == StFault);
    end
  end

  assign coin_out_o    = coin_out_q;
  assign remaining_o   = rem_q;
  assign payout_busy_o = busy_q;
  assign payout_done_o = done_q;
  assign hopper_err_o  = err_q;

endmodule

// File: tb/tb_coin_payout.sv
// Self-checking bench for coin_payout: per-coin timeline model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_coin_payout;

  localparam int P    = 4;
  localparam int G    = 8;
  localparam int A    = 200;
  localparam int MAXP = 9;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [3:0] cur_state  = 4'd2;
  logic       win_valid  = 1'b0;
  logic [3:0] win_amt    = 4'd0;
  logic       hopper_ack = 1'b0;
  logic       err_clr    = 1'b0;
  logic       coin_out;
  logic [3:0] remaining;
  logic       payout_busy;
  logic       payout_done;
  logic       hopper_err;

  int n_checks = 0;
  int n_err    = 0;

  // Model: per-coin timeline. m_t counts cycles since the current coin's pulse began.
  int m_owed   = 0;
  int m_t      = 0;
  int m_ack_t  = -1;
  int m_resume = -1;
  bit m_paying = 1'b0;
  bit m_done   = 1'b0;
  bit m_fault  = 1'b0;

  int   pulse_cnt = 0;
  int   done_cnt  = 0;
  int   high_len  = 0;
  int   last_high = 0;
  logic prev_coin = 1'b0;

  coin_payout #(
    .PulseCyc  (P),
    .GapCyc    (G),
    .AckTimeout(A),
    .MaxPayout (MAXP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cur_state_i  (cur_state),
    .win_valid_i  (win_valid),
    .win_amt_i    (win_amt),
    .hopper_ack_i (hopper_ack),
    .err_clr_i    (err_clr),
    .coin_out_o   (coin_out),
    .remaining_o  (remaining),
    .payout_busy_o(payout_busy),
    .payout_done_o(payout_done),
    .hopper_err_o (hopper_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owed   = 0;
    m_t      = 0;
    m_ack_t  = -1;
    m_resume = -1;
    m_paying = 1'b0;
    m_done   = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] cs, input logic wv, input logic [3:0] amt,
                            input logic ack, input logic clr);
    if (m_fault) begin
      if (clr) begin
        m_fault = 1'b0;
        m_owed  = 0;
      end
      return;
    end
    if (cs == 4'd3) begin
      m_paying = 1'b0;
      m_done   = 1'b0;
      m_owed   = 0;
      return;
    end
    if (m_done) begin
      m_done = 1'b0;
      m_owed = 0;
      return;
    end
    if (!m_paying) begin
      if (wv && cs == 4'd2) begin
        m_owed = (int'(amt) > MAXP) ? MAXP : int'(amt);
        if (m_owed == 0) m_done = 1'b1;
        else begin
          m_paying = 1'b1;
          m_t      = 0;
          m_ack_t  = -1;
          m_resume = -1;
        end
      end
      return;
    end
    if (m_resume < 0) begin
      if (ack && m_ack_t < 0) m_ack_t = m_t;
      if (m_ack_t >= 0 && m_t >= P - 1) begin
        m_owed--;
        if (m_owed == 0) begin
          m_paying = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_resume = m_t + G + 1;
        end
      end else if (m_t == P - 1 + A) begin
        m_paying = 1'b0;
        m_fault  = 1'b1;
      end
    end
    m_t++;
    if (m_resume >= 0 && m_t == m_resume) begin
      m_t      = 0;
      m_ack_t  = -1;
      m_resume = -1;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(cur_state, win_valid, win_amt, hopper_ack, err_clr);
    #1;
    check("coin_out", coin_out, (m_paying && m_resume < 0 && m_t < P) ? 1 : 0);
    check("remaining", remaining, m_owed);
    check("payout_busy", payout_busy, (m_paying || m_done) ? 1 : 0);
    check("payout_done", payout_done, m_done ? 1 : 0);
    check("hopper_err", hopper_err, m_fault ? 1 : 0);
    if (coin_out === 1'b1) begin
      if (prev_coin !== 1'b1) begin
        pulse_cnt++;
        high_len = 1;
      end else begin
        high_len++;
      end
    end else begin
      if (prev_coin === 1'b1) last_high = high_len;
      high_len = 0;
    end
    prev_coin = coin_out;
    if (payout_done === 1'b1) done_cnt++;
  end

  task automatic start_win(input logic [3:0] amt);
    win_amt   = amt;
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
  endtask

  task automatic wait_coin(input logic lvl, input int budget, input string name);
    int n = 0;
    while (coin_out !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, coin_out, lvl);
  endtask

  task automatic serve_coin(input int delay);
    wait_coin(1'b1, 50, "serve_rise");
    wait_coin(1'b0, 20, "serve_fall");
    repeat (delay) @(negedge clk);
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int p0;
    int d0;
    repeat (3) @(negedge clk);
    check("reset_coin", coin_out, 0);
    check("reset_rem", remaining, 0);
    check("reset_busy", payout_busy, 0);
    check("reset_err", hopper_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three coins, ack 5 cycles after each pulse end
    p0 = pulse_cnt;
    d0 = done_cnt;
    start_win(4'd3);
    check("t1_latency", coin_out, 1);
    check("t1_rem_init", remaining, 3);
    for (int i = 0; i < 3; i++) begin
      serve_coin(4);
      check("t1_rem_step", remaining, 2 - i);
    end
    check("t1_done", payout_done, 1);
    @(negedge clk);
    check("t1_busy_fall", payout_busy, 0);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_pulses", pulse_cnt - p0, 3);
    check("t1_width", last_high, 4);

    // 2: cap at nine coins, then a zero-coin win
    p0 = pulse_cnt;
    start_win(4'd12);
    check("t2_rem_cap", remaining, 9);
    repeat (9) serve_coin(0);
    check("t2_done", payout_done, 1);
    @(negedge clk);
    check("t2_pulses", pulse_cnt - p0, 9);
    p0 = pulse_cnt;
    start_win(4'd0);
    check("t2_zero_done", payout_done, 1);
    check("t2_zero_coin", coin_out, 0);
    @(negedge clk);
    check("t2_zero_done_fall", payout_done, 0);
    check("t2_zero_pulses", pulse_cnt - p0, 0);

    // 3: win outside SCORE, and a second win during a payout, are ignored
    p0 = pulse_cnt;
    d0 = done_cnt;
    cur_state = 4'd1;
    start_win(4'd5);
    repeat (20) @(negedge clk);
    check("t3_game_pulses", pulse_cnt - p0, 0);
    check("t3_game_busy", payout_busy, 0);
    cur_state = 4'd2;
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    start_win(4'd1);
    @(negedge clk);
    start_win(4'd7);
    serve_coin(2);
    repeat (20) @(negedge clk);
    check("t3_busy_pulses", pulse_cnt - p0, 1);
    check("t3_busy_done", done_cnt - d0, 1);
    check("t3_rem_end", remaining, 0);

    // 4: hopper never acks -> fault, then clear and pay again
    start_win(4'd2);
    wait_coin(1'b0, 20, "t4_fall");
    repeat (A - 1) @(negedge clk);
    check("t4_err_early", hopper_err, 0);
    @(negedge clk);
    check("t4_err_set", hopper_err, 1);
    check("t4_rem_hold", remaining, 2);
    check("t4_busy", payout_busy, 0);
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    cur_state = 4'd3;
    @(negedge clk);
    cur_state = 4'd2;
    check("t4_err_sticky", hopper_err, 1);
    check("t4_rem_sticky", remaining, 2);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", hopper_err, 0);
    check("t4_rem_clr", remaining, 0);
    start_win(4'd1);
    serve_coin(1);
    check("t4_new_done", payout_done, 1);
    @(negedge clk);

    // 5: ack inside the pulse, stray ack in GAP, abort mid-GAP
    p0 = pulse_cnt;
    d0 = done_cnt;
    start_win(4'd2);
    hopper_ack = 1'b1;
    repeat (2) @(negedge clk);
    hopper_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_gap_coin", coin_out, 0);
    check("t5_rem_once", remaining, 1);
    check("t5_gap_busy", payout_busy, 1);
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    check("t5_gap_ack_ign", remaining, 1);
    cur_state = 4'd3;
    @(negedge clk);
    cur_state = 4'd2;
    check("t5_abort_rem", remaining, 0);
    check("t5_abort_busy", payout_busy, 0);
    repeat (20) @(negedge clk);
    check("t5_abort_pulses", pulse_cnt - p0, 1);
    check("t5_abort_nodone", done_cnt - d0, 0);

    // 6: asynchronous reset in the middle of a pulse
    start_win(4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_coin", coin_out, 0);
    check("t6_busy", payout_busy, 0);
    check("t6_rem", remaining, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_win(4'd1);
    serve_coin(0);
    check("t6_recover_done", payout_done, 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
